// File: rtl/window_serializer_if.sv
`default_nettype none
// ============================================================================
// window_serializer_if : block-load and pixel-stream handshake bundle
// Revision: 1.0
// ============================================================================
interface window_serializer_if #(
   parameter int N           = 3,
   parameter int PXL_CHANNEL = 8
);
   logic                                  i_load;
   logic [N-1:0][2:0][PXL_CHANNEL-1:0]    i_whole_data;
   logic                                  o_ready;
   logic                                  i_ready;
   logic                                  o_enable_tx;
   logic [2:0][PXL_CHANNEL-1:0]           o_data;
   logic                                  o_last;
   logic                                  o_eol;

   // master = block source / pixel sink, slave = the serializer
   modport master (
      output i_load, i_whole_data, i_ready,
      input  o_ready, o_enable_tx, o_data, o_last, o_eol
   );

   modport slave (
      input  i_load, i_whole_data, i_ready,
      output o_ready, o_enable_tx, o_data, o_last, o_eol
   );
endinterface
`default_nettype wire

// File: rtl/window_serializer.sv
`default_nettype none
// ============================================================================
// window_serializer : N-pixel parallel block in, one pixel per transfer out,
//                     oldest first, with raster end-of-line flagging.
// Revision: 1.0
// ============================================================================
module window_serializer #(
   parameter int N           = 3,
   parameter int PXL_CHANNEL = 8,
   parameter int LINE_W      = 640
) (
   input  logic                      i_clk,
   input  logic                      i_reset_n,
   window_serializer_if.slave        bus
);

   localparam int c_CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam int c_COL_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(N - 1);
   localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(LINE_W - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
   localparam logic [c_COL_W-1:0] c_COL_ONE  = c_COL_W'(1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_SEND = 1'b1
   } state_t;

   state_t                              r_state;
   state_t                              w_state_nxt;
   logic [N-1:0][2:0][PXL_CHANNEL-1:0]  r_buf;
   logic [c_CNT_W-1:0]                  r_cnt;
   logic [c_CNT_W-1:0]                  w_cnt_nxt;
   logic [c_COL_W-1:0]                  r_col;
   logic [c_COL_W-1:0]                  w_col_nxt;
   logic [c_CNT_W-1:0]                  w_idx;
   logic                                w_send;
   logic                                w_at_last;
   logic                                w_xfer;
   logic                                w_ready;
   logic                                w_capture;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= S_IDLE;
         r_buf   <= '0;
         r_cnt   <= '0;
         r_col   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_col   <= w_col_nxt;
         if (w_capture) begin
            r_buf <= bus.i_whole_data;
         end
      end
   end

   always_comb begin
      w_send      = (r_state == S_SEND);
      w_at_last   = w_send && (r_cnt == c_CNT_LAST);
      w_xfer      = w_send && bus.i_ready;
      // A new block slots in on the same edge the final pixel leaves
      w_ready     = !w_send || (w_at_last && bus.i_ready);
      w_capture   = bus.i_load && w_ready;
      w_idx       = c_CNT_LAST - r_cnt;
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_col_nxt   = r_col;

      case (r_state)
         S_IDLE: begin
            if (bus.i_load) begin
               w_state_nxt = S_SEND;
               w_cnt_nxt   = '0;
            end
         end
         S_SEND: begin
            if (w_xfer) begin
               if (!w_at_last) begin
                  w_cnt_nxt = r_cnt + c_CNT_ONE;
               end else begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = bus.i_load ? S_SEND : S_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase

      if (w_xfer) begin
         w_col_nxt = (r_col == c_COL_LAST) ? '0 : r_col + c_COL_ONE;
      end
   end

   assign bus.o_ready     = w_ready;
   assign bus.o_enable_tx = w_send;
   assign bus.o_data      = w_send ? r_buf[w_idx] : '0;
   assign bus.o_last      = w_at_last;
   assign bus.o_eol       = w_send && (r_col == c_COL_LAST);

endmodule
`default_nettype wire

// File: doc/window_serializer.md
Name: window_serializer

Overview:
- Parallel-in, serial-out pixel stage, the transmit-side counterpart of the window shift register.
- Accepts a block of N RGB pixels in one transfer, in the same packed layout as the window buffer's whole-register output (index N-1 = oldest).
- Emits the pixels one per accepted cycle, oldest first, on an enable-qualified pixel stream.
- Tracks raster column position and flags end-of-line, so a downstream window buffer receives pixels in their original order.

Parameters:
- N, 3, pixels per parallel block; must be ≥ 2.
- PXL_CHANNEL, 8, bits per colour channel.
- LINE_W, 640, pixels per image line, used for end-of-line flagging; must be ≥ 1.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_load  in  1  parallel block valid.
- i_whole_data  in  [N-1:0][2:0][PXL_CHANNEL-1:0]  parallel block; element N-1 is the oldest pixel.
- o_ready  out  1  block accepted this cycle when high together with i_load.
- i_ready  in  1  downstream can take a pixel this cycle.
- o_enable_tx  out  1  o_data valid.
- o_data  out  [2:0][PXL_CHANNEL-1:0]  current pixel.
- o_last  out  1  o_data is the final pixel of the current block.
- o_eol  out  1  o_data is the last pixel of an image line.

Behaviour:
- Reset (async, i_reset_n low):
  - state=IDLE, block buffer=0, pixel counter cnt=0, column counter col=0.
  - Outputs during and after reset: o_ready=1, o_enable_tx=0, o_data=0, o_last=0, o_eol=0.
  - Reset mid-block discards the remaining pixels; nothing further is emitted.
- State machine: IDLE, SEND.
  - IDLE:
    - o_ready=1, o_enable_tx=0.
    - i_load=1: capture i_whole_data into buffer, cnt<=0, go to SEND.
    - i_load=0: stay in IDLE.
  - SEND:
    - o_enable_tx=1, o_data=buffer[N-1-cnt], o_last=(cnt==N-1).
    - Pixel transfer happens only on a cycle with o_enable_tx & i_ready. Without i_ready, o_data, o_last and o_eol hold stable (no pixel dropped or repeated).
    - On a transfer with cnt<N-1: cnt<=cnt+1.
    - On a transfer with cnt==N-1 and i_load=1: reload buffer, cnt<=0, stay in SEND. Back-to-back blocks have no bubble cycle.
    - On a transfer with cnt==N-1 and i_load=0: go to IDLE, cnt<=0.
- o_ready:
  - o_ready = (state==IDLE) | (state==SEND & cnt==N-1 & i_ready).
  - This is the only combinational input-to-output path (from i_ready).
  - i_load while o_ready=0 is ignored. The source must hold i_load and i_whole_data until accepted.
- Latency: the first pixel appears on o_data the cycle after the load is accepted. A full block needs N transfer cycles with i_ready held high.
- Column tracking:
  - o_eol = o_enable_tx & (col==LINE_W-1).
  - col increments on each transfer and wraps LINE_W-1 -> 0.
  - col persists across blocks and IDLE periods; only reset clears it.
  - For LINE_W=1, o_eol=o_enable_tx.
- Widths: cnt is $clog2(N) bits, col is $clog2(LINE_W) bits (minimum 1). Neither counter ever exceeds its terminal value.
- o_data is driven from registers only, with no combinational path from i_whole_data.

Test Plan:
- Reset, then hold i_reset_n=1 with no load -> o_ready=1, o_enable_tx=0, o_data=0 indefinitely.
- N=3, load {p2=0x0A0B0C, p1=0x1A1B1C, p0=0x2A2B2C}, i_ready=1 -> next three cycles o_data=0x0A0B0C, 0x1A1B1C, 0x2A2B2C with o_enable_tx=1; o_last high only on the third cycle; then o_enable_tx=0.
- Same block, i_ready toggling 1,0,0,1,1 -> output held stable during the low cycles; exactly three pixels transferred, in order, with none repeated.
- Two blocks back-to-back, i_load held high, i_ready=1 -> six consecutive valid cycles with no gap; o_ready=1 only on cycles 3 and 6 of emission.
- LINE_W=4, N=3, four blocks with i_ready=1 -> o_eol high on transfers 4, 8 and 12, including the case where the line end falls mid-block.
- Assert i_reset_n=0 after the first pixel of a block -> all outputs 0 and o_ready=1 immediately; after release, a new load emits from its oldest pixel with col restarting at 0.
